// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo_ctrl slice: pointer wrap arithmetic,
// occupancy-width helper and threshold sanity check used at elaboration.
// Pure functions and types only; no state, no clocking.
package sync_fifo_pkg;

  // Plain unsigned index type used for pointer and width arithmetic.
  typedef int unsigned idx_t;

  // Advance a pointer by one, wrapping to 0 after depth-1 so that depths
  // that are not powers of two never visit unused addresses.
  function automatic idx_t ptr_inc(idx_t ptr, idx_t depth);
    return (ptr == depth - 1) ? idx_t'(0) : ptr + 1;
  endfunction

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic idx_t count_w(idx_t depth);
    return idx_t'($clog2(depth + 1));
  endfunction

  // Thresholds must leave a gap between the two almost flags and must be
  // reachable by the occupancy counter.
  function automatic bit thresh_ok(idx_t ae, idx_t af, idx_t depth);
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Bundle of the FIFO control, data and status signals.
// master = producer/consumer side, slave = FIFO side.
// No logic; flow control is the wr_en/full and rd_en/empty handshake.
interface sync_fifo_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clear;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W storage array for the FIFO.
// Write takes effect at the clock edge; read is combinational from raddr.
// No backpressure: the controller only asserts we for accepted writes.
module sync_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost flags and sticky errors.
// Read latency 1 cycle (registered rd_data); 0 cycles with SYNC_FIFO_FWFT_EN (head fall-through).
// Writes while full are rejected (overflow) unless a read is accepted the same cycle; reads while empty set underflow.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  sync_fifo_if.slave    bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  if (!thresh_ok(idx_t'(AE_THRESH), idx_t'(AF_THRESH), idx_t'(DEPTH))) begin : g_bad_thresh
    $error("sync_fifo_ctrl: need AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (DEPTH < 2 || DATA_W < 1) begin : g_bad_size
    $error("sync_fifo_ctrl: need DEPTH >= 2 and DATA_W >= 1");
  end
  if (count_w(idx_t'(DEPTH)) != idx_t'(CNT_W)) begin : g_bad_cnt_w
    $error("sync_fifo_ctrl: count width mismatch");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_q, udf_q;
  logic              full_w, empty_w;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] head;

  // Every flag comes from the occupancy register, never from pointer compare.
  assign full_w  = (cnt == CNT_W'(DEPTH));
  assign empty_w = (cnt == '0);

  assign rd_acc = bus.rd_en & ~empty_w;
  assign wr_acc = bus.wr_en & (~full_w | rd_acc);

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~bus.clear),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers, occupancy and sticky error bits; clear overrides any access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ADDR_W'(ptr_inc(idx_t'(wr_ptr), idx_t'(DEPTH)));
      if (rd_acc) rd_ptr <= ADDR_W'(ptr_inc(idx_t'(rd_ptr), idx_t'(DEPTH)));
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (bus.wr_en && !wr_acc) ovf_q <= 1'b1;
      if (bus.rd_en && !rd_acc) udf_q <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd_en only pops it.
  assign bus.rd_data  = head;
  assign bus.rd_valid = ~empty_w;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Output register loads the head on an accepted read and holds otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (bus.clear) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= head;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (cnt <= CNT_W'(AE_THRESH));
  assign bus.count        = cnt;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl at DEPTH=5 (AF=3, AE=2).
// Table of hand-computed vectors, then queue-checked multi-cycle sequences.
module tb_sync_fifo_ctrl;

  localparam int DW = 16;
  localparam int DP = 5;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  sync_fifo_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic          clr, we, re;
    logic [DW-1:0] wd;
    int            cnt;
    logic          full, empty, af, ae, ovf, udf, rv;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vt [18];

  logic [DW-1:0] q [$];
  logic          m_ovf, m_udf, m_rv;
  logic [DW-1:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    bus.clear   = c;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // One cycle against the queue model; checks state after the edge.
  task automatic op(input logic c, input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit racc, wacc;
    racc = !c && r && (q.size() > 0);
    wacc = !c && w && ((q.size() < DP) || racc);
`ifdef SYNC_FIFO_FWFT_EN
    if (racc) chk({tag, ".head"}, 32'(bus.rd_data), 32'(q[0]));
`endif
    drive(c, w, r, d);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      m_rv = racc;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(d);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_udf = 1'b1;
    end
    chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ".full"},  32'(bus.full),  32'(q.size() == DP));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".ovf"},   32'(bus.overflow),  32'(m_ovf));
    chk({tag, ".udf"},   32'(bus.underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ".rv"}, 32'(bus.rd_valid), 32'(q.size() > 0));
`else
    chk({tag, ".rv"}, 32'(bus.rd_valid), 32'(m_rv));
    chk({tag, ".rd"}, 32'(bus.rd_data),  32'(m_rd));
`endif
  endtask

  initial begin
    //         clr we re  wd      cnt full emp af ae ovf udf rv rd
    vt[0]  = '{0, 1, 0, 16'h0011, 1, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
    vt[1]  = '{0, 1, 0, 16'h0022, 2, 0, 0, 0, 1, 0, 0, 0, 16'h0000};
    vt[2]  = '{0, 1, 0, 16'h0033, 3, 0, 0, 1, 0, 0, 0, 0, 16'h0000};
    vt[3]  = '{0, 1, 0, 16'h0044, 4, 0, 0, 1, 0, 0, 0, 0, 16'h0000};
    vt[4]  = '{0, 1, 0, 16'h0055, 5, 1, 0, 1, 0, 0, 0, 0, 16'h0000};
    vt[5]  = '{0, 1, 0, 16'h0066, 5, 1, 0, 1, 0, 1, 0, 0, 16'h0000};
    vt[6]  = '{0, 0, 1, 16'h0000, 4, 0, 0, 1, 0, 1, 0, 1, 16'h0011};
    vt[7]  = '{0, 0, 1, 16'h0000, 3, 0, 0, 1, 0, 1, 0, 1, 16'h0022};
    vt[8]  = '{0, 0, 1, 16'h0000, 2, 0, 0, 0, 1, 1, 0, 1, 16'h0033};
    vt[9]  = '{0, 0, 1, 16'h0000, 1, 0, 0, 0, 1, 1, 0, 1, 16'h0044};
    vt[10] = '{0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 1, 0, 1, 16'h0055};
    vt[11] = '{0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 1, 1, 0, 16'h0055};
    vt[12] = '{0, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 1, 1, 0, 16'h0055};
    vt[13] = '{1, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0055};
    vt[14] = '{0, 1, 1, 16'h00AA, 1, 0, 0, 0, 1, 0, 1, 0, 16'h0055};
    vt[15] = '{0, 0, 1, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 1, 16'h00AA};
    vt[16] = '{1, 1, 0, 16'h00BB, 0, 0, 1, 0, 1, 0, 0, 0, 16'h00AA};
    vt[17] = '{0, 0, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 0, 0, 16'h00AA};

    resetn = 1'b0;
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    #12;
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.empty", 32'(bus.empty), 1);
    chk("rst.full",  32'(bus.full), 0);
    chk("rst.ae",    32'(bus.almost_empty), 1);
    chk("rst.af",    32'(bus.almost_full), 0);
    chk("rst.ovf",   32'(bus.overflow), 0);
    chk("rst.udf",   32'(bus.underflow), 0);
    chk("rst.rv",    32'(bus.rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst.rd",    32'(bus.rd_data), 0);
`endif
    resetn = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].clr, vt[i].we, vt[i].re, vt[i].wd);
      chk($sformatf("v%0d.count", i), 32'(bus.count), 32'(vt[i].cnt));
      chk($sformatf("v%0d.full", i),  32'(bus.full),  32'(vt[i].full));
      chk($sformatf("v%0d.empty", i), 32'(bus.empty), 32'(vt[i].empty));
      chk($sformatf("v%0d.af", i),    32'(bus.almost_full),  32'(vt[i].af));
      chk($sformatf("v%0d.ae", i),    32'(bus.almost_empty), 32'(vt[i].ae));
      chk($sformatf("v%0d.ovf", i),   32'(bus.overflow),  32'(vt[i].ovf));
      chk($sformatf("v%0d.udf", i),   32'(bus.underflow), 32'(vt[i].udf));
`ifndef SYNC_FIFO_FWFT_EN
      chk($sformatf("v%0d.rv", i),    32'(bus.rd_valid), 32'(vt[i].rv));
      chk($sformatf("v%0d.rd", i),    32'(bus.rd_data),  32'(vt[i].rd));
`endif
    end

    // Model now matches the end of the table: empty, flags clear, rd_data=AA.
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = 16'h00AA;

    // Pointer wrap: 13 writes with concurrent reads from the third onward.
    for (int i = 0; i < 13; i++)
      op(1'b0, 1'b1, (i >= 2), DW'(16'h0100 + i), $sformatf("wrap%0d", i));
    op(1'b0, 1'b0, 1'b1, '0, "wrap_d0");
    op(1'b0, 1'b0, 1'b1, '0, "wrap_d1");

    // Full with simultaneous write and read: both accepted, no overflow.
    for (int i = 0; i < DP; i++)
      op(1'b0, 1'b1, 1'b0, DW'(16'h00C0 + i), $sformatf("fill%0d", i));
    op(1'b0, 1'b1, 1'b1, 16'h00C5, "full_rw");
    chk("full_rw.no_ovf", 32'(bus.overflow), 0);
    chk("full_rw.cnt5",   32'(bus.count), 5);

    // Overflow, drain to 3, then clear together with a write.
    op(1'b0, 1'b1, 1'b0, 16'h00DD, "ovf_wr");
    op(1'b0, 1'b0, 1'b1, '0, "to3_a");
    op(1'b0, 1'b0, 1'b1, '0, "to3_b");
    chk("pre_clr.cnt3", 32'(bus.count), 3);
    chk("pre_clr.ovf",  32'(bus.overflow), 1);
    op(1'b1, 1'b1, 1'b0, 16'h00EE, "clr_wr");
    op(1'b0, 1'b0, 1'b0, '0, "post_clr");

    // Reset mid-operation discards everything at once.
    op(1'b0, 1'b1, 1'b0, 16'h0031, "prerst_a");
    op(1'b0, 1'b1, 1'b0, 16'h0032, "prerst_b");
    op(1'b0, 1'b0, 1'b1, '0, "prerst_c");
    resetn = 1'b0;
    #1;
    chk("midrst.count", 32'(bus.count), 0);
    chk("midrst.empty", 32'(bus.empty), 1);
    chk("midrst.rv",    32'(bus.rd_valid), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("midrst.rd",    32'(bus.rd_data), 0);
`endif
    #1;
    resetn = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
    op(1'b0, 1'b1, 1'b0, 16'h0077, "postrst_wr");
    op(1'b0, 1'b0, 1'b1, '0, "postrst_rd");

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: word visible the cycle after the write, no rd_en needed.
    op(1'b0, 1'b1, 1'b0, 16'h00A5, "fwft_wr");
    chk("fwft.rv", 32'(bus.rd_valid), 1);
    chk("fwft.rd", 32'(bus.rd_data), 32'h00A5);
    op(1'b0, 1'b0, 1'b1, '0, "fwft_pop");
    chk("fwft.empty", 32'(bus.empty), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
